// File: rtl/free_list.sv
// Physical-register free list: hands out up to four free pregs per cycle in program
// order, reclaims retired mappings, and rewinds the speculative head on mispredict.
module free_list #(
  parameter int PREG_W   = 7,
  parameter int NUM_PREG = 128,
  parameter int NUM_AREG = 32,
  parameter int DEPTH    = NUM_PREG - NUM_AREG
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              inst0_rd_we_i,
  input  logic              inst1_rd_we_i,
  input  logic              inst2_rd_we_i,
  input  logic              inst3_rd_we_i,
  input  logic              arch_stall_i,
  output logic [PREG_W-1:0] inst0_prd_o,
  output logic [PREG_W-1:0] inst1_prd_o,
  output logic [PREG_W-1:0] inst2_prd_o,
  output logic [PREG_W-1:0] inst3_prd_o,
  output logic              fl_stall_o,
  input  logic              ret0_we_i,
  input  logic              ret1_we_i,
  input  logic              ret2_we_i,
  input  logic              ret3_we_i,
  input  logic [PREG_W-1:0] ret0_old_prd_i,
  input  logic [PREG_W-1:0] ret1_old_prd_i,
  input  logic [PREG_W-1:0] ret2_old_prd_i,
  input  logic [PREG_W-1:0] ret3_old_prd_i,
  input  logic              recover_i,
  output logic              ovf_err_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 2;

  logic [PREG_W-1:0] fl_mem_q [0:DEPTH-1];
  logic [PTR_W-1:0]  head_q, arch_head_q, tail_q;
  logic [PTR_W-1:0]  head_d, arch_head_d, tail_d;
  logic [CNT_W-1:0]  spec_cnt_q, arch_cnt_q, spec_cnt_d, arch_cnt_d;
  logic              ovf_q, ovf_d;

  logic [3:0]                   req, rel;
  logic [3:0][PREG_W-1:0]       prd, rel_prd;
  logic [3:0][PTR_W-1:0]        rel_idx;
  logic [2:0]                   req_cnt, rel_cnt, alloc_cnt;
  logic                         alloc;
  logic [SUM_W-1:0]             cnt_sum;

  // Pointers are not a power of two, so wrap by explicit compare.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                input logic [2:0] k);
    logic [PTR_W:0] s;
    s = {1'b0, p} + {{(PTR_W-2){1'b0}}, k};
    if (s >= (PTR_W+1)'(DEPTH)) s = s - (PTR_W+1)'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  assign req     = {inst3_rd_we_i, inst2_rd_we_i, inst1_rd_we_i, inst0_rd_we_i};
  assign rel     = {ret3_we_i, ret2_we_i, ret1_we_i, ret0_we_i};
  assign rel_prd = {ret3_old_prd_i, ret2_old_prd_i, ret1_old_prd_i, ret0_old_prd_i};

  // The k-th requester reads head+k; slot order keeps grants in program order.
  always_comb begin
    req_cnt = '0;
    prd     = '0;
    for (int n = 0; n < 4; n++) begin
      if (req[n]) prd[n] = fl_mem_q[wrap_add(head_q, req_cnt)];
      req_cnt = req_cnt + 3'(req[n]);
    end
  end

  always_comb begin
    rel_cnt = '0;
    rel_idx = '0;
    for (int n = 0; n < 4; n++) begin
      rel_idx[n] = wrap_add(tail_q, rel_cnt);
      rel_cnt    = rel_cnt + 3'(rel[n]);
    end
  end

  assign inst0_prd_o = prd[0];
  assign inst1_prd_o = prd[1];
  assign inst2_prd_o = prd[2];
  assign inst3_prd_o = prd[3];
  assign fl_stall_o  = CNT_W'(req_cnt) > spec_cnt_q;
  assign ovf_err_o   = ovf_q;

  assign alloc     = ~fl_stall_o & ~arch_stall_i & ~recover_i;
  assign alloc_cnt = alloc ? req_cnt : 3'd0;
  assign cnt_sum   = SUM_W'(spec_cnt_q) + SUM_W'(rel_cnt) - SUM_W'(alloc_cnt);

  // Retirement frees and commits the same count, so arch_cnt holds steady.
  always_comb begin
    arch_head_d = wrap_add(arch_head_q, rel_cnt);
    tail_d      = wrap_add(tail_q, rel_cnt);
    arch_cnt_d  = arch_cnt_q;
    ovf_d       = ovf_q | (cnt_sum > SUM_W'(DEPTH));
    head_d      = head_q;
    spec_cnt_d  = CNT_W'(cnt_sum);
    if (recover_i) begin
      head_d     = arch_head_d;
      spec_cnt_d = arch_cnt_q;
    end else if (alloc) begin
      head_d = wrap_add(head_q, req_cnt);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) fl_mem_q[i] <= PREG_W'(NUM_AREG + i);
      head_q      <= '0;
      arch_head_q <= '0;
      tail_q      <= '0;
      spec_cnt_q  <= CNT_W'(DEPTH);
      arch_cnt_q  <= CNT_W'(DEPTH);
      ovf_q       <= 1'b0;
    end else begin
      for (int n = 0; n < 4; n++)
        if (rel[n]) fl_mem_q[rel_idx[n]] <= rel_prd[n];
      head_q      <= head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
      spec_cnt_q  <= spec_cnt_d;
      arch_cnt_q  <= arch_cnt_d;
      ovf_q       <= ovf_d;
    end
  end
endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed scenarios then random traffic against a queue model
// holding the committed ring (arch_q) and the count of speculatively free entries.
module tb_free_list;
  localparam int DEPTH = 96;

  logic       clock, reset_n;
  logic [3:0] req, rw;
  logic       st, rc;
  logic [6:0] rv [4];
  logic [6:0] p0, p1, p2, p3;
  logic       stall, ovf;

  int tests, fails;
  int arch_q[$];
  int spec_len;
  bit ovf_m;

  free_list dut (
    .clock(clock), .reset_n(reset_n),
    .inst0_rd_we_i(req[0]), .inst1_rd_we_i(req[1]),
    .inst2_rd_we_i(req[2]), .inst3_rd_we_i(req[3]),
    .arch_stall_i(st),
    .inst0_prd_o(p0), .inst1_prd_o(p1), .inst2_prd_o(p2), .inst3_prd_o(p3),
    .fl_stall_o(stall),
    .ret0_we_i(rw[0]), .ret1_we_i(rw[1]), .ret2_we_i(rw[2]), .ret3_we_i(rw[3]),
    .ret0_old_prd_i(rv[0]), .ret1_old_prd_i(rv[1]),
    .ret2_old_prd_i(rv[2]), .ret3_old_prd_i(rv[3]),
    .recover_i(rc), .ovf_err_o(ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    arch_q.delete();
    for (int i = 0; i < DEPTH; i++) arch_q.push_back(32 + i);
    spec_len = DEPTH;
    ovf_m    = 1'b0;
  endtask

  function automatic logic [6:0] prd_of(input int n);
    case (n)
      0: return p0;
      1: return p1;
      2: return p2;
      default: return p3;
    endcase
  endfunction

  // One clock: check outputs against the model, take the edge, advance the model.
  task automatic cycle();
    int k, rq_n, rl_n, ac;
    bit stall_m;
    #1;
    rq_n = $countones(req);
    rl_n = $countones(rw);
    stall_m = rq_n > spec_len;
    if (reset_n) begin
      k = 0;
      for (int n = 0; n < 4; n++) begin
        if (req[n]) begin
          chk($sformatf("prd%0d", n), 32'(prd_of(n)), arch_q[(DEPTH - spec_len + k) % DEPTH]);
          k++;
        end else chk($sformatf("prd%0d_idle", n), 32'(prd_of(n)), 0);
      end
      chk("fl_stall", 32'(stall), 32'(stall_m));
      chk("ovf_err", 32'(ovf), 32'(ovf_m));
    end
    @(posedge clock);
    if (!reset_n) model_reset();
    else begin
      ac = (!stall_m && !st && !rc) ? rq_n : 0;
      if (spec_len + rl_n - ac > DEPTH) ovf_m = 1'b1;
      for (int n = 0; n < 4; n++)
        if (rw[n]) begin
          void'(arch_q.pop_front());
          arch_q.push_back(int'(rv[n]));
        end
      spec_len = rc ? DEPTH : spec_len + rl_n - ac;
    end
    @(negedge clock);
  endtask

  task automatic set_in(input logic [3:0] r, input logic s, input logic c, input logic [3:0] w);
    req = r; st = s; rc = c; rw = w;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_in(4'b0, 1'b0, 1'b0, 4'b0);
    cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    tests = 0; fails = 0;
    reset_n = 1'b0;
    set_in(4'b0, 1'b0, 1'b0, 4'b0);
    for (int i = 0; i < 4; i++) rv[i] = '0;
    model_reset();
    @(negedge clock);
    do_reset();

    // Reset image, two full-width allocations.
    set_in(4'b1111, 0, 0, 0); #1;
    chk("t1_p0", p0, 32); chk("t1_p3", p3, 35); chk("t1_ovf", ovf, 0);
    cycle();
    #1; chk("t1_next_p0", p0, 36); chk("t1_next_p3", p3, 39);
    cycle();

    // Sparse request pattern.
    do_reset();
    set_in(4'b1010, 0, 0, 0); #1;
    chk("t2_p0", p0, 0); chk("t2_p1", p1, 32); chk("t2_p2", p2, 0); chk("t2_p3", p3, 33);
    cycle();
    set_in(4'b0001, 0, 0, 0); #1; chk("t2_head2", p0, 34);
    cycle();

    // Drain, stall on empty, refill by retirement.
    do_reset();
    for (int i = 0; i < 24; i++) begin set_in(4'b1111, 0, 0, 0); cycle(); end
    set_in(4'b0001, 0, 0, 0); #1; chk("t3_stall", stall, 1);
    cycle();
    set_in(4'b0001, 0, 0, 0); #1; chk("t3_stall_hold", stall, 1);
    cycle();
    rv[0] = 7'd5; set_in(4'b0000, 0, 0, 4'b0001); cycle();
    set_in(4'b0001, 0, 0, 0); #1;
    chk("t3_reuse", p0, 5); chk("t3_nostall", stall, 0);
    cycle();

    // Recovery rewinds head; same-cycle request is not granted.
    do_reset();
    set_in(4'b0111, 0, 0, 0); cycle();
    set_in(4'b1111, 0, 1, 0); cycle();
    set_in(4'b0001, 0, 0, 0); #1; chk("t4_rewind", p0, 32);
    cycle();
    set_in(4'b0001, 1, 0, 0); cycle();
    set_in(4'b0001, 0, 0, 0); #1; chk("t4_archstall", p0, 33);
    cycle();

    // Head wraps 94,95,0,1.
    do_reset();
    for (int i = 0; i < 23; i++) begin set_in(4'b1111, 0, 0, 0); cycle(); end
    set_in(4'b0011, 0, 0, 0); cycle();
    rv[0] = 10; rv[1] = 11; rv[2] = 12; rv[3] = 13;
    set_in(4'b0000, 0, 0, 4'b1111); cycle();
    set_in(4'b1111, 0, 0, 0); #1;
    chk("t5_w0", p0, 126); chk("t5_w1", p1, 127); chk("t5_w2", p2, 10); chk("t5_w3", p3, 11);
    cycle();

    // Reset mid-burst, then overflow detection.
    do_reset();
    for (int i = 0; i < 4; i++) begin set_in(4'b1111, 0, 0, 0); cycle(); end
    set_in(4'b0001, 0, 0, 0); cycle();
    reset_n = 1'b0; set_in(4'b1111, 0, 0, 0); cycle(); reset_n = 1'b1;
    #1; chk("t6_p0", p0, 32); chk("t6_p3", p3, 35); chk("t6_ovf0", ovf, 0);
    cycle();
    do_reset();
    rv[0] = 7'd7; set_in(4'b0000, 0, 0, 4'b0001); cycle();
    set_in(4'b0000, 0, 0, 0); #1; chk("t6_ovf1", ovf, 1);
    cycle();
    #1; chk("t6_ovf_sticky", ovf, 1);
    cycle();
    do_reset();
    #1; chk("t6_ovf_clr", ovf, 0);

    // Random traffic; retirement bounded so the list never overflows.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) == 0) begin do_reset(); continue; end
      set_in(4'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0),
             4'($urandom));
      if ($countones(rw) > DEPTH - spec_len) rw = '0;
      for (int n = 0; n < 4; n++) rv[n] = 7'($urandom_range(0, 127));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
